// File: rtl/trigger_power_threshold.sv
// Sliding-window power trigger: squares each sample, sums a WINDOW_CLKS-clock window,
// and fires a rate-limited single-cycle trigger when the window power exceeds a threshold.
module trigger_power_threshold #(
    parameter int NSAMP       = 8,
    parameter int NBITS       = 12,
    parameter int WINDOW_CLKS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   aclk,
    input  logic                   aclk_rst_i,
    input  logic [NSAMP*NBITS-1:0] dat_i,
    input  logic                   enable_i,
    input  logic [31:0]            threshold_i,
    input  logic [15:0]            holdoff_i,
    input  logic                   cnt_clear_i,
    output logic [31:0]            power_o,
    output logic                   trig_o,
    output logic [CNT_W-1:0]       trig_count_o,
    output logic                   armed_o
);

    // The square of the most negative sample (-2^(NBITS-1)) is exactly 2^(2*NBITS-2), so
    // SQ_W = 2*NBITS-1 unsigned bits hold every square; the window sum adds log2(#samples) bits.
    localparam int SQ_W  = 2*NBITS - 1;
    localparam int BLK_W = SQ_W + $clog2(NSAMP);
    localparam int RUN_W = SQ_W + $clog2(NSAMP*WINDOW_CLKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    logic [SQ_W-1:0]  sq [NSAMP];
    logic [BLK_W-1:0] blk_sum;
    logic [BLK_W-1:0] blk;
    logic [BLK_W-1:0] blk_dly [WINDOW_CLKS];
    logic [RUN_W-1:0] run;
    state_t           state;
    logic [15:0]      hcnt;

    function automatic logic [SQ_W-1:0] square(input logic [NBITS-1:0] s);
        logic signed [2*NBITS-1:0] ext;
        logic signed [2*NBITS-1:0] prod;
        ext  = {{NBITS{s[NBITS-1]}}, s};
        prod = ext * ext;
        return prod[SQ_W-1:0];
    endfunction

    // Stage 1: per-sample squares.
    always_ff @(posedge aclk) begin
        if (aclk_rst_i) begin
            for (int k = 0; k < NSAMP; k++) sq[k] <= '0;
        end else begin
            for (int k = 0; k < NSAMP; k++) sq[k] <= square(dat_i[NBITS*k +: NBITS]);
        end
    end

    // NOTE: combinational accumulators use blocking '=' with a default first so no latch is inferred.
    always_comb begin
        blk_sum = '0;
        for (int k = 0; k < NSAMP; k++) blk_sum = blk_sum + BLK_W'(sq[k]);
    end

    // Stages 2 and 3: block sum, window delay line and running sum.
    // NOTE: the delay line is reset explicitly; leaving it uninitialised would let stale
    // pre-reset blocks be subtracted from the fresh running sum and underflow it.
    always_ff @(posedge aclk) begin
        if (aclk_rst_i) begin
            blk <= '0;
            for (int i = 0; i < WINDOW_CLKS; i++) blk_dly[i] <= '0;
            run <= '0;
        end else begin
            blk        <= blk_sum;
            blk_dly[0] <= blk;
            for (int i = 1; i < WINDOW_CLKS; i++) blk_dly[i] <= blk_dly[i-1];
            run <= run + RUN_W'(blk) - RUN_W'(blk_dly[WINDOW_CLKS-1]);
        end
    end

    always_comb begin
        power_o            = '0;
        power_o[RUN_W-1:0] = run;
    end

    // Trigger FSM; trig_o and armed_o are registered alongside the state.
    always_ff @(posedge aclk) begin
        if (aclk_rst_i) begin
            state   <= IDLE;
            hcnt    <= '0;
            trig_o  <= 1'b0;
            armed_o <= 1'b0;
        end else begin
            trig_o <= 1'b0;
            if (!enable_i) begin
                state   <= IDLE;
                armed_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= ARMED;
                        armed_o <= 1'b1;
                    end
                    ARMED: begin
                        if (power_o > threshold_i) begin
                            trig_o  <= 1'b1;
                            hcnt    <= holdoff_i;
                            state   <= HOLDOFF;
                            armed_o <= 1'b0;
                        end
                    end
                    HOLDOFF: begin
                        if (hcnt == '0) begin
                            state   <= ARMED;
                            armed_o <= 1'b1;
                        end else begin
                            hcnt <= hcnt - 16'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        armed_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating count of issued pulses; a simultaneous clear wins.
    always_ff @(posedge aclk) begin
        if (aclk_rst_i || cnt_clear_i) begin
            trig_count_o <= '0;
        end else if (trig_o && (trig_count_o != {CNT_W{1'b1}})) begin
            trig_count_o <= trig_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trigger_power_threshold.sv
// Directed bench for trigger_power_threshold; a second instance with a 4-bit counter
// exercises counter saturation within a short run.
module tb_trigger_power_threshold;

    logic        aclk = 1'b0;
    logic        rst;
    logic [95:0] dat;
    logic        en;
    logic [31:0] thr;
    logic [15:0] hold;
    logic        clr;

    logic [31:0] power;
    logic        trig;
    logic [15:0] count;
    logic        armed;

    logic [31:0] power_s;
    logic        trig_s;
    logic [3:0]  count_s;
    logic        armed_s;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    trigger_power_threshold dut (
        .aclk         (aclk),
        .aclk_rst_i   (rst),
        .dat_i        (dat),
        .enable_i     (en),
        .threshold_i  (thr),
        .holdoff_i    (hold),
        .cnt_clear_i  (clr),
        .power_o      (power),
        .trig_o       (trig),
        .trig_count_o (count),
        .armed_o      (armed)
    );

    trigger_power_threshold #(.CNT_W(4)) dut_sat (
        .aclk         (aclk),
        .aclk_rst_i   (rst),
        .dat_i        (dat),
        .enable_i     (en),
        .threshold_i  (thr),
        .holdoff_i    (hold),
        .cnt_clear_i  (clr),
        .power_o      (power_s),
        .trig_o       (trig_s),
        .trig_count_o (count_s),
        .armed_o      (armed_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic fill(input logic [11:0] v);
        dat = {8{v}};
    endtask

    // Window power for a constant stream whose 8-sample block power is blk, n clocks after it starts.
    function automatic logic [63:0] exp_power(input int n, input logic [63:0] blk);
        if (n < 3) return 64'd0;
        if (n >= 6) return 4 * blk;
        return 64'(n - 2) * blk;
    endfunction

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        thr  = 32'hFFFF_FFFF;
        hold = 16'd0;
        clr  = 1'b0;
        dat  = '0;
        tick();
        tick();
        check("rst_power", 64'(power), 64'd0);
        check("rst_trig",  64'(trig),  64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_armed", 64'(armed), 64'd0);
        rst = 1'b0;

        // All-zero input: nothing accumulates, nothing fires.
        for (int n = 1; n <= 20; n++) begin
            tick();
            check($sformatf("zero_power@%0d", n), 64'(power), 64'd0);
            check($sformatf("zero_trig@%0d", n),  64'(trig),  64'd0);
        end
        check("zero_count", 64'(count), 64'd0);

        // Constant 100: window ramps by 80000 per clock, triggers every 2 clocks with holdoff 0.
        fill(12'd100);
        en   = 1'b1;
        thr  = 32'd239999;
        hold = 16'd0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            check($sformatf("ramp_power@%0d", n), 64'(power), exp_power(n, 64'd80000));
            check($sformatf("ramp_trig@%0d", n),  64'(trig),  64'((n >= 6) && (n % 2 == 0)));
            check($sformatf("ramp_armed@%0d", n), 64'(armed), 64'((n <= 5) || (n % 2 == 1)));
            check($sformatf("ramp_count@%0d", n), 64'(count), (n >= 7) ? 64'((n - 5) / 2) : 64'd0);
        end

        // Reset while in HOLDOFF with a full window.
        rst = 1'b1;
        tick();
        check("midrst_power", 64'(power), 64'd0);
        check("midrst_trig",  64'(trig),  64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_armed", 64'(armed), 64'd0);
        rst  = 1'b0;
        hold = 16'd5;

        // Holdoff 5: triggers spaced 7 clocks apart.
        for (int n = 1; n <= 22; n++) begin
            tick();
            check($sformatf("hold_power@%0d", n), 64'(power), exp_power(n, 64'd80000));
            check($sformatf("hold_trig@%0d", n),  64'(trig),  64'(n == 6 || n == 13 || n == 20));
        end
        check("hold_count", 64'(count), 64'd3);

        // Back to holdoff 0 once the in-flight holdoff drains; many triggers for saturation.
        hold = 16'd0;
        for (int n = 23; n <= 82; n++) begin
            tick();
            check($sformatf("fast_trig@%0d", n), 64'(trig), 64'(n == 27 || (n >= 29 && n % 2 == 1)));
        end
        check("fast_count",   64'(count),   64'd31);
        check("sat_count",    64'(count_s), 64'd15);
        check("sat_power",    64'(power_s), 64'd320000);
        check("sat_trig",     64'(trig_s),  64'd0);
        check("sat_armed",    64'(armed_s), 64'd1);
        check("fast_armed",   64'(armed),   64'd1);

        // Clear coinciding with a trigger pulse wins.
        tick();
        check("clr_trig", 64'(trig), 64'd1);
        clr = 1'b1;
        tick();
        check("clr_count",     64'(count),   64'd0);
        check("clr_count_sat", 64'(count_s), 64'd0);
        clr = 1'b0;
        tick();
        check("post_clr_trig", 64'(trig), 64'd1);
        tick();
        check("post_clr_count", 64'(count), 64'd1);
        check("pre_drop_armed", 64'(armed), 64'd1);

        // Drop enable on the clock where the threshold crossing would fire.
        en = 1'b0;
        tick();
        check("drop_trig",  64'(trig),  64'd0);
        check("drop_armed", 64'(armed), 64'd0);
        tick();
        check("drop_trig2",  64'(trig),  64'd0);
        check("drop_armed2", 64'(armed), 64'd0);
        check("drop_count",  64'(count), 64'd1);

        // Full-scale negative input: largest window power, no overflow, unreachable threshold.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fill(12'h800);
        thr = 32'hFFFF_FFFF;
        en  = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check($sformatf("max_power@%0d", n), 64'(power), exp_power(n, 64'd33554432));
            check($sformatf("max_trig@%0d", n),  64'(trig),  64'd0);
        end
        check("max_armed", 64'(armed), 64'd1);
        check("max_count", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
